br_amba_axil_mux: RTL and testbench

- N-to-1 AXI4-Lite initiator multiplexer/arbiter.
- Shares one downstream AXI4-Lite target port among NumInitiators upstream AXI4-Lite initiators.
- Read and write paths are arbitrated independently, each with round-robin priority.
- Per-path tracker FIFOs record grant order so that B and R responses are routed back to the issuing initiator. Typical use: several bridge or CSR masters sharing one register-block port.

---
 rtl/br_amba_axil_mux_pkg.sv | 10 +
 rtl/br_amba_axil_mux_tracker.sv | 100 ++++++++++
 rtl/br_amba_axil_mux.sv | 145 ++++++++++++++
 tb/tb_br_amba_axil_mux.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_amba_axil_mux_pkg.sv
// Shared widths and arbitration state encoding for the AXI4-Lite initiator mux.
package br_amba_axil_mux_pkg;
    localparam int AxiProtWidth = 3;
    localparam int AxiRespWidth = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } arb_state_e;
endpackage

// File: rtl/br_amba_axil_mux_tracker.sv
// One request path: round-robin grant, grant latch and an order-tracking FIFO
// whose head names the initiator owed the next response.
module br_amba_axil_mux_tracker
    import br_amba_axil_mux_pkg::*;
#(
    parameter int NumInitiators = 2,
    parameter int Depth         = 16,
    localparam int GrantWidth   = $clog2(NumInitiators)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NumInitiators-1:0] i_req,
    input  logic                     i_done,
    input  logic                     i_pop,
    output logic                     o_active,
    output logic [GrantWidth-1:0]    o_grant,
    output logic [GrantWidth-1:0]    o_head,
    output logic                     o_empty
);
    localparam int PtrWidth = $clog2(Depth);
    localparam int CntWidth = $clog2(Depth + 1);

    arb_state_e            r_state;
    logic [GrantWidth-1:0] r_grant;
    logic [GrantWidth-1:0] r_prio;
    logic [GrantWidth-1:0] r_mem [Depth];
    logic [PtrWidth-1:0]   r_wptr;
    logic [PtrWidth-1:0]   r_rptr;
    logic [CntWidth-1:0]   r_count;

    logic                  w_any;
    logic                  w_space;
    logic                  w_push;
    logic [GrantWidth-1:0] w_pick;
    logic [GrantWidth:0]   w_idx;

    // A pop in the same cycle frees a slot before the eventual push lands.
    assign w_space = (r_count != CntWidth'(Depth)) || i_pop;
    assign w_push  = (r_state == ST_ACTIVE) && i_done;

    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = '0;
        for (int k = 0; k < NumInitiators; k++) begin
            w_idx = {1'b0, r_prio} + (GrantWidth + 1)'(k);
            if (w_idx >= (GrantWidth + 1)'(NumInitiators))
                w_idx = w_idx - (GrantWidth + 1)'(NumInitiators);
            if (!w_any && i_req[w_idx[GrantWidth-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_idx[GrantWidth-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_prio  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any && w_space) begin
                        r_state <= ST_ACTIVE;
                        r_grant <= w_pick;
                        r_prio  <= (w_pick == GrantWidth'(NumInitiators - 1)) ? '0 : w_pick + 1'b1;
                    end
                end
                ST_ACTIVE: if (i_done) r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= r_grant;
                r_wptr <= (r_wptr == PtrWidth'(Depth - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (i_pop)
                r_rptr <= (r_rptr == PtrWidth'(Depth - 1)) ? '0 : r_rptr + 1'b1;
            case ({w_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_active = (r_state == ST_ACTIVE);
    assign o_grant  = r_grant;
    assign o_head   = r_mem[r_rptr];
    assign o_empty  = (r_count == '0);
endmodule

// File: rtl/br_amba_axil_mux.sv
// N-to-1 AXI4-Lite initiator mux: independent round-robin read/write arbitration,
// responses steered back through per-path grant-order trackers.
module br_amba_axil_mux
    import br_amba_axil_mux_pkg::*;
#(
    parameter int NumInitiators      = 2,
    parameter int AddrWidth          = 12,
    parameter int DataWidth          = 32,
    parameter int ReqUserWidth       = 8,
    parameter int ReqDataUserWidth   = 8,
    parameter int RespUserWidth      = 8,
    parameter int MaxOutstandingReqs = 16,
    localparam int StrobeWidth       = DataWidth / 8,
    localparam int GrantWidth        = $clog2(NumInitiators)
) (
    input  logic                                              i_clk,
    input  logic                                              i_rst,
    input  logic [NumInitiators-1:0][AddrWidth-1:0]           i_init_axil_awaddr,
    input  logic [NumInitiators-1:0][AxiProtWidth-1:0]        i_init_axil_awprot,
    input  logic [NumInitiators-1:0][ReqUserWidth-1:0]        i_init_axil_awuser,
    input  logic [NumInitiators-1:0]                          i_init_axil_awvalid,
    output logic [NumInitiators-1:0]                          o_init_axil_awready,
    input  logic [NumInitiators-1:0][DataWidth-1:0]           i_init_axil_wdata,
    input  logic [NumInitiators-1:0][StrobeWidth-1:0]         i_init_axil_wstrb,
    input  logic [NumInitiators-1:0][ReqDataUserWidth-1:0]    i_init_axil_wuser,
    input  logic [NumInitiators-1:0]                          i_init_axil_wvalid,
    output logic [NumInitiators-1:0]                          o_init_axil_wready,
    output logic [NumInitiators-1:0][AxiRespWidth-1:0]        o_init_axil_bresp,
    output logic [NumInitiators-1:0][RespUserWidth-1:0]       o_init_axil_buser,
    output logic [NumInitiators-1:0]                          o_init_axil_bvalid,
    input  logic [NumInitiators-1:0]                          i_init_axil_bready,
    input  logic [NumInitiators-1:0][AddrWidth-1:0]           i_init_axil_araddr,
    input  logic [NumInitiators-1:0][AxiProtWidth-1:0]        i_init_axil_arprot,
    input  logic [NumInitiators-1:0][ReqUserWidth-1:0]        i_init_axil_aruser,
    input  logic [NumInitiators-1:0]                          i_init_axil_arvalid,
    output logic [NumInitiators-1:0]                          o_init_axil_arready,
    output logic [NumInitiators-1:0][DataWidth-1:0]           o_init_axil_rdata,
    output logic [NumInitiators-1:0][AxiRespWidth-1:0]        o_init_axil_rresp,
    output logic [NumInitiators-1:0][RespUserWidth-1:0]       o_init_axil_ruser,
    output logic [NumInitiators-1:0]                          o_init_axil_rvalid,
    input  logic [NumInitiators-1:0]                          i_init_axil_rready,
    output logic [AddrWidth-1:0]                              o_axil_awaddr,
    output logic [AxiProtWidth-1:0]                           o_axil_awprot,
    output logic [ReqUserWidth-1:0]                           o_axil_awuser,
    output logic                                              o_axil_awvalid,
    input  logic                                              i_axil_awready,
    output logic [DataWidth-1:0]                              o_axil_wdata,
    output logic [StrobeWidth-1:0]                            o_axil_wstrb,
    output logic [ReqDataUserWidth-1:0]                       o_axil_wuser,
    output logic                                              o_axil_wvalid,
    input  logic                                              i_axil_wready,
    input  logic [AxiRespWidth-1:0]                           i_axil_bresp,
    input  logic [RespUserWidth-1:0]                          i_axil_buser,
    input  logic                                              i_axil_bvalid,
    output logic                                              o_axil_bready,
    output logic [AddrWidth-1:0]                              o_axil_araddr,
    output logic [AxiProtWidth-1:0]                           o_axil_arprot,
    output logic [ReqUserWidth-1:0]                           o_axil_aruser,
    output logic                                              o_axil_arvalid,
    input  logic                                              i_axil_arready,
    input  logic [DataWidth-1:0]                              i_axil_rdata,
    input  logic [AxiRespWidth-1:0]                           i_axil_rresp,
    input  logic [RespUserWidth-1:0]                          i_axil_ruser,
    input  logic                                              i_axil_rvalid,
    output logic                                              o_axil_rready
);
    logic                  w_wr_active, w_wr_empty, w_wr_done, w_aw_hs, w_w_hs, w_b_pop;
    logic                  w_rd_active, w_rd_empty, w_rd_done, w_r_pop;
    logic [GrantWidth-1:0] w_wr_grant, w_wr_head, w_rd_grant, w_rd_head;
    logic                  r_aw_done, r_w_done;

    br_amba_axil_mux_tracker #(.NumInitiators(NumInitiators), .Depth(MaxOutstandingReqs)) u_wr_trk (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_init_axil_awvalid), .i_done(w_wr_done),
        .i_pop(w_b_pop), .o_active(w_wr_active), .o_grant(w_wr_grant), .o_head(w_wr_head),
        .o_empty(w_wr_empty)
    );

    br_amba_axil_mux_tracker #(.NumInitiators(NumInitiators), .Depth(MaxOutstandingReqs)) u_rd_trk (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_init_axil_arvalid), .i_done(w_rd_done),
        .i_pop(w_r_pop), .o_active(w_rd_active), .o_grant(w_rd_grant), .o_head(w_rd_head),
        .o_empty(w_rd_empty)
    );

    assign o_axil_awaddr  = i_init_axil_awaddr[w_wr_grant];
    assign o_axil_awprot  = i_init_axil_awprot[w_wr_grant];
    assign o_axil_awuser  = i_init_axil_awuser[w_wr_grant];
    assign o_axil_awvalid = w_wr_active && i_init_axil_awvalid[w_wr_grant] && !r_aw_done;
    assign o_axil_wdata   = i_init_axil_wdata[w_wr_grant];
    assign o_axil_wstrb   = i_init_axil_wstrb[w_wr_grant];
    assign o_axil_wuser   = i_init_axil_wuser[w_wr_grant];
    assign o_axil_wvalid  = w_wr_active && i_init_axil_wvalid[w_wr_grant] && !r_w_done;
    assign w_aw_hs        = o_axil_awvalid && i_axil_awready;
    assign w_w_hs         = o_axil_wvalid && i_axil_wready;
    assign w_wr_done      = w_wr_active && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

    assign o_axil_araddr  = i_init_axil_araddr[w_rd_grant];
    assign o_axil_arprot  = i_init_axil_arprot[w_rd_grant];
    assign o_axil_aruser  = i_init_axil_aruser[w_rd_grant];
    assign o_axil_arvalid = w_rd_active && i_init_axil_arvalid[w_rd_grant];
    assign w_rd_done      = o_axil_arvalid && i_axil_arready;

    // Responses only route once a tracker entry exists, keeping reset outputs clean.
    assign o_axil_bready     = !w_wr_empty && i_init_axil_bready[w_wr_head];
    assign o_axil_rready     = !w_rd_empty && i_init_axil_rready[w_rd_head];
    assign w_b_pop           = i_axil_bvalid && o_axil_bready;
    assign w_r_pop           = i_axil_rvalid && o_axil_rready;
    assign o_init_axil_bresp = {NumInitiators{i_axil_bresp}};
    assign o_init_axil_buser = {NumInitiators{i_axil_buser}};
    assign o_init_axil_rdata = {NumInitiators{i_axil_rdata}};
    assign o_init_axil_rresp = {NumInitiators{i_axil_rresp}};
    assign o_init_axil_ruser = {NumInitiators{i_axil_ruser}};

    always_comb begin
        o_init_axil_awready = '0;
        o_init_axil_wready  = '0;
        o_init_axil_arready = '0;
        o_init_axil_bvalid  = '0;
        o_init_axil_rvalid  = '0;
        if (w_wr_active) begin
            o_init_axil_awready[w_wr_grant] = i_axil_awready && !r_aw_done;
            o_init_axil_wready[w_wr_grant]  = i_axil_wready && !r_w_done;
        end
        if (w_rd_active) o_init_axil_arready[w_rd_grant] = i_axil_arready;
        if (!w_wr_empty) o_init_axil_bvalid[w_wr_head] = i_axil_bvalid;
        if (!w_rd_empty) o_init_axil_rvalid[w_rd_head] = i_axil_rvalid;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_wr_done) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_aw_done <= r_aw_done || w_aw_hs;
            r_w_done  <= r_w_done || w_w_hs;
        end
    end

    // A response with no tracked request means the target was not reset with us.
    always @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(i_axil_bvalid && w_wr_empty));
            assert (!(i_axil_rvalid && w_rd_empty));
        end
    end
endmodule

// File: tb/tb_br_amba_axil_mux.sv
// Directed bench for br_amba_axil_mux with two initiators and a 2-deep tracker.
module tb_br_amba_axil_mux;
    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    logic [1:0][11:0] init_awaddr, init_araddr;
    logic [1:0][2:0]  init_awprot, init_arprot;
    logic [1:0][7:0]  init_awuser, init_aruser, init_wuser;
    logic [1:0]       init_awvalid, init_awready, init_wvalid, init_wready;
    logic [1:0][31:0] init_wdata, init_rdata;
    logic [1:0][3:0]  init_wstrb;
    logic [1:0][1:0]  init_bresp, init_rresp;
    logic [1:0][7:0]  init_buser, init_ruser;
    logic [1:0]       init_bvalid, init_bready, init_arvalid, init_arready, init_rvalid, init_rready;
    logic [11:0]      axil_awaddr, axil_araddr;
    logic [2:0]       axil_awprot, axil_arprot;
    logic [7:0]       axil_awuser, axil_aruser, axil_wuser, axil_buser, axil_ruser;
    logic             axil_awvalid, axil_awready, axil_wvalid, axil_wready, axil_bvalid, axil_bready;
    logic             axil_arvalid, axil_arready, axil_rvalid, axil_rready;
    logic [31:0]      axil_wdata, axil_rdata;
    logic [3:0]       axil_wstrb;
    logic [1:0]       axil_bresp, axil_rresp;

    int n_checks = 0;
    int n_errors = 0;

    br_amba_axil_mux #(.NumInitiators(2), .MaxOutstandingReqs(2)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_init_axil_awaddr(init_awaddr), .i_init_axil_awprot(init_awprot),
        .i_init_axil_awuser(init_awuser), .i_init_axil_awvalid(init_awvalid),
        .o_init_axil_awready(init_awready),
        .i_init_axil_wdata(init_wdata), .i_init_axil_wstrb(init_wstrb),
        .i_init_axil_wuser(init_wuser), .i_init_axil_wvalid(init_wvalid),
        .o_init_axil_wready(init_wready),
        .o_init_axil_bresp(init_bresp), .o_init_axil_buser(init_buser),
        .o_init_axil_bvalid(init_bvalid), .i_init_axil_bready(init_bready),
        .i_init_axil_araddr(init_araddr), .i_init_axil_arprot(init_arprot),
        .i_init_axil_aruser(init_aruser), .i_init_axil_arvalid(init_arvalid),
        .o_init_axil_arready(init_arready),
        .o_init_axil_rdata(init_rdata), .o_init_axil_rresp(init_rresp),
        .o_init_axil_ruser(init_ruser), .o_init_axil_rvalid(init_rvalid),
        .i_init_axil_rready(init_rready),
        .o_axil_awaddr(axil_awaddr), .o_axil_awprot(axil_awprot), .o_axil_awuser(axil_awuser),
        .o_axil_awvalid(axil_awvalid), .i_axil_awready(axil_awready),
        .o_axil_wdata(axil_wdata), .o_axil_wstrb(axil_wstrb), .o_axil_wuser(axil_wuser),
        .o_axil_wvalid(axil_wvalid), .i_axil_wready(axil_wready),
        .i_axil_bresp(axil_bresp), .i_axil_buser(axil_buser), .i_axil_bvalid(axil_bvalid),
        .o_axil_bready(axil_bready),
        .o_axil_araddr(axil_araddr), .o_axil_arprot(axil_arprot), .o_axil_aruser(axil_aruser),
        .o_axil_arvalid(axil_arvalid), .i_axil_arready(axil_arready),
        .i_axil_rdata(axil_rdata), .i_axil_rresp(axil_rresp), .i_axil_ruser(axil_ruser),
        .i_axil_rvalid(axil_rvalid), .o_axil_rready(axil_rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        init_awaddr = '0; init_awprot = '0; init_awuser = '0; init_awvalid = '0;
        init_wdata = '0; init_wstrb = '0; init_wuser = '0; init_wvalid = '0;
        init_bready = '0; init_araddr = '0; init_arprot = '0; init_aruser = '0;
        init_arvalid = '0; init_rready = '0;
        axil_awready = 1'b0; axil_wready = 1'b0; axil_arready = 1'b0;
        axil_bresp = '0; axil_buser = '0; axil_bvalid = 1'b0;
        axil_rdata = '0; axil_rresp = '0; axil_ruser = '0; axil_rvalid = 1'b0;
        repeat (3) cyc();
        #1;
        chk("rst_awvalid", axil_awvalid, 0);
        chk("rst_wvalid", axil_wvalid, 0);
        chk("rst_arvalid", axil_arvalid, 0);
        chk("rst_init_awready", init_awready, 0);
        chk("rst_init_arready", init_arready, 0);
        chk("rst_bready", axil_bready, 0);
        rst = 1'b0;

        // single write from initiator 1
        cyc();
        init_awvalid[1] = 1'b1; init_awaddr[1] = 12'h123;
        init_wvalid[1] = 1'b1; init_wdata[1] = 32'hCAFE0001; init_wstrb[1] = 4'hF;
        axil_awready = 1'b1; axil_wready = 1'b1;
        #1;
        chk("t1_idle_awvalid", axil_awvalid, 0);
        cyc(); #1;
        chk("t1_awvalid", axil_awvalid, 1);
        chk("t1_awaddr", axil_awaddr, 12'h123);
        chk("t1_wvalid", axil_wvalid, 1);
        chk("t1_wdata", axil_wdata, 32'hCAFE0001);
        chk("t1_init_awready", init_awready, 2'b10);
        chk("t1_init_wready", init_wready, 2'b10);
        cyc();
        init_awvalid[1] = 1'b0; init_wvalid[1] = 1'b0;
        axil_bvalid = 1'b1; axil_buser = 8'h5A; init_bready = 2'b11;
        #1;
        chk("t1_back_idle", axil_awvalid, 0);
        chk("t1_bvalid", init_bvalid, 2'b10);
        chk("t1_buser", init_buser[1], 8'h5A);
        chk("t1_bready", axil_bready, 1);

        // W ahead of AW on initiator 0
        cyc();
        axil_bvalid = 1'b0;
        init_wvalid[0] = 1'b1; init_wdata[0] = 32'h11112222; init_wstrb[0] = 4'hF;
        axil_awready = 1'b0; axil_wready = 1'b1;
        #1;
        chk("t3_wvalid_idle", axil_wvalid, 0);
        cyc(); cyc(); cyc();
        init_awvalid[0] = 1'b1; init_awaddr[0] = 12'h0A0;
        #1;
        chk("t3_wready_wait", init_wready, 2'b00);
        cyc(); #1;
        chk("t3_wvalid", axil_wvalid, 1);
        chk("t3_awvalid", axil_awvalid, 1);
        chk("t3_init_wready", init_wready, 2'b01);
        chk("t3_init_awready_stall", init_awready, 2'b00);
        cyc();
        init_wvalid[0] = 1'b0;
        #1;
        chk("t3_wvalid_done", axil_wvalid, 0);
        chk("t3_awaddr", axil_awaddr, 12'h0A0);
        axil_awready = 1'b1;
        #1;
        chk("t3_init_awready", init_awready, 2'b01);
        cyc();
        init_awvalid[0] = 1'b0; axil_bvalid = 1'b1;
        #1;
        chk("t3_bvalid", init_bvalid, 2'b01);

        // AW stall with initiator 1 arriving mid-stall
        cyc();
        axil_bvalid = 1'b0;
        init_awvalid[0] = 1'b1; init_awaddr[0] = 12'h200;
        init_wvalid[0] = 1'b1; init_wdata[0] = 32'h00000200;
        axil_awready = 1'b0; axil_wready = 1'b0;
        cyc(); #1;
        chk("t5_awaddr_s1", axil_awaddr, 12'h200);
        cyc();
        init_awvalid[1] = 1'b1; init_awaddr[1] = 12'h300;
        init_wvalid[1] = 1'b1; init_wdata[1] = 32'h00000300;
        #1;
        chk("t5_awaddr_s2", axil_awaddr, 12'h200);
        chk("t5_awready_stall", init_awready, 2'b00);
        cyc(); cyc(); #1;
        chk("t5_awaddr_s4", axil_awaddr, 12'h200);
        cyc();
        cyc();
        axil_awready = 1'b1; axil_wready = 1'b1;
        #1;
        chk("t5_init_awready", init_awready, 2'b01);
        chk("t5_awaddr_hs", axil_awaddr, 12'h200);
        cyc();
        init_awvalid[0] = 1'b0; init_wvalid[0] = 1'b0;
        #1;
        chk("t5_gap_awvalid", axil_awvalid, 0);
        cyc(); #1;
        chk("t5_next_awaddr", axil_awaddr, 12'h300);
        chk("t5_next_wdata", axil_wdata, 32'h00000300);
        chk("t5_next_awready", init_awready, 2'b10);
        cyc();
        init_awvalid[1] = 1'b0; init_wvalid[1] = 1'b0; axil_bvalid = 1'b1;
        #1;
        chk("t5_b_first", init_bvalid, 2'b01);
        cyc(); #1;
        chk("t5_b_second", init_bvalid, 2'b10);

        // two initiators reading back to back
        cyc();
        axil_bvalid = 1'b0;
        init_arvalid = 2'b11; init_araddr[0] = 12'h010; init_araddr[1] = 12'h020;
        axil_arready = 1'b1; init_rready = 2'b11;
        #1;
        chk("t2_idle_arvalid", axil_arvalid, 0);
        cyc(); #1;
        chk("t2_g0_addr", axil_araddr, 12'h010);
        chk("t2_g0_rdy", init_arready, 2'b01);
        cyc(); #1;
        chk("t2_idle2_arvalid", axil_arvalid, 0);
        cyc(); #1;
        chk("t2_g1_addr", axil_araddr, 12'h020);
        chk("t2_g1_rdy", init_arready, 2'b10);
        cyc();
        axil_rvalid = 1'b1; axil_rdata = 32'hD0;
        #1;
        chk("t2_r0", init_rvalid, 2'b01);
        chk("t2_r0_data", init_rdata[0], 32'hD0);
        chk("t2_full_arvalid", axil_arvalid, 0);
        cyc();
        axil_rdata = 32'hD1;
        #1;
        chk("t2_r1", init_rvalid, 2'b10);
        chk("t2_g2_addr", axil_araddr, 12'h010);
        chk("t2_g2_rdy", init_arready, 2'b01);
        cyc();
        axil_rdata = 32'hD2;
        #1;
        chk("t2_r2", init_rvalid, 2'b01);
        cyc();
        axil_rvalid = 1'b0;
        #1;
        chk("t2_g3_addr", axil_araddr, 12'h020);
        chk("t2_g3_rdy", init_arready, 2'b10);
        cyc();
        init_arvalid = 2'b00; axil_rvalid = 1'b1;
        #1;
        chk("t2_r3", init_rvalid, 2'b10);

        // tracker full holds off the third read
        cyc();
        axil_rvalid = 1'b0;
        init_arvalid = 2'b01; init_rready = 2'b01;
        cyc(); #1;
        chk("t4_g0_rdy", init_arready, 2'b01);
        cyc();
        cyc(); #1;
        chk("t4_g1_rdy", init_arready, 2'b01);
        cyc(); #1;
        chk("t4_full_a", init_arready, 2'b00);
        cyc();
        cyc();
        axil_rvalid = 1'b1; axil_rdata = 32'hE0;
        #1;
        chk("t4_full_b", init_arready, 2'b00);
        chk("t4_r", init_rvalid, 2'b01);
        cyc();
        axil_rvalid = 1'b0;
        #1;
        chk("t4_regrant", init_arready, 2'b01);

        // reset with a write in flight and the read tracker full
        cyc();
        init_awvalid[1] = 1'b1; init_awaddr[1] = 12'h3FF; init_wvalid[1] = 1'b1;
        axil_awready = 1'b0; axil_wready = 1'b0; init_arvalid = 2'b11;
        cyc(); #1;
        chk("t6_pre_awvalid", axil_awvalid, 1);
        chk("t6_pre_arready", init_arready, 2'b00);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        init_awvalid = 2'b11; init_wvalid = 2'b11;
        axil_awready = 1'b1; axil_wready = 1'b1;
        #1;
        chk("t6_awvalid", axil_awvalid, 0);
        chk("t6_wvalid", axil_wvalid, 0);
        chk("t6_arvalid", axil_arvalid, 0);
        chk("t6_init_awready", init_awready, 2'b00);
        chk("t6_init_wready", init_wready, 2'b00);
        chk("t6_init_arready", init_arready, 2'b00);
        chk("t6_rready_empty", axil_rready, 0);
        cyc(); #1;
        chk("t6_rd_prio", init_arready, 2'b01);
        chk("t6_wr_prio", init_awready, 2'b01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
